sound_scheduler: RTL and testbench

SOUND_SCHEDULER -- requirements
Module: sound_scheduler

---
 rtl/sound_pkg.sv | 28 ++
 rtl/frame_tick_sync.sv | 22 ++
 rtl/sound_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_sound_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared state type, per-sound tone tables and amplitude default for sound_scheduler.
// Table order: bounce, brick, paddle, lose.
package sound_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StGap
  } sched_state_e;

  localparam int unsigned NumSounds = 4;

  localparam logic [19:0] AMP_DEFAULT = 20'h0_8000;

  // Frames per half square-wave period and total frames per sound.
  localparam logic [15:0] HALF_PERIOD [NumSounds] = '{16'd10, 16'd16, 16'd24, 16'd40};
  localparam logic [15:0] DURATION    [NumSounds] = '{16'd400, 16'd800, 16'd4800, 16'd1600};

  // A zero entry would never expire, so it behaves as a single frame.
  function automatic logic [15:0] half_period_of(logic [1:0] idx);
    return (HALF_PERIOD[idx] == 16'd0) ? 16'd1 : HALF_PERIOD[idx];
  endfunction

  function automatic logic [15:0] duration_of(logic [1:0] idx);
    return (DURATION[idx] == 16'd0) ? 16'd1 : DURATION[idx];
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the codec frame-ready strobe into system_clock and emits one pulse per rising edge.
module frame_tick_sync (
  input  logic system_clock,
  input  logic reset,
  input  logic ready,
  output logic frame_tick
);

  // [0],[1] form the synchroniser; [2] holds the previous synchronised level.
  logic [2:0] sync_q;

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], ready};
    end
  end

  assign frame_tick = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/sound_scheduler.sv
// Priority scheduler driving square-wave sound effects onto the AC97 left/right slots.
// Define SOUND_QUEUE_EN to latch losing requests and serve them when the gap ends.
module sound_scheduler
  import sound_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter logic [19:0] AMP        = AMP_DEFAULT,
  parameter int unsigned GAP_FRAMES = 240
) (
  input  logic                                       system_clock,
  input  logic                                       reset,
  input  logic                                       ready,
  input  logic [NUM_REQ-1:0]                         req,
  output logic [NUM_REQ-1:0]                         ack,
  output logic                                       busy,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] active_id,
  output logic [19:0]                                left_out_data,
  output logic [19:0]                                right_out_data
);

  localparam int unsigned IdW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] GapLoad = (GAP_FRAMES == 0) ? 16'd1 : 16'(GAP_FRAMES);
  localparam logic [19:0] NegAmp  = 20'(~AMP + 20'd1);

  logic frame_tick;

  frame_tick_sync u_frame_tick_sync (
    .system_clock (system_clock),
    .reset        (reset),
    .ready        (ready),
    .frame_tick   (frame_tick)
  );

  sched_state_e   state_q, state_d;
  logic [IdW-1:0] id_q, id_d;
  logic           neg_q, neg_d;
  logic [15:0]    half_q, half_d;
  logic [15:0]    dur_q, dur_d;
  logic [15:0]    gap_q, gap_d;

  logic [NUM_REQ-1:0] ack_d;
  logic               req_any;
  logic [IdW-1:0]     req_win;
  logic               start;
  logic [IdW-1:0]     start_id;

  always_comb begin
    req_any = |req;
    req_win = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[i]) req_win = IdW'(i);
    end
  end

`ifdef SOUND_QUEUE_EN
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] eligible;
  logic [IdW-1:0]     pend_win;

  // A request arriving on the gap's last frame competes with those already queued.
  always_comb begin
    eligible = pending_q | req;
    pend_win = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (eligible[i]) pend_win = IdW'(i);
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    neg_d    = neg_q;
    half_d   = half_q;
    dur_d    = dur_q;
    gap_d    = gap_q;
    ack_d    = '0;
    start    = 1'b0;
    start_id = req_win;

    unique case (state_q)
      StIdle: begin
        if (req_any) start = 1'b1;
      end

      StPlay: begin
        // Preemption takes priority over a coincident frame tick.
        if (req_any && (req_win < id_q)) begin
          start = 1'b1;
        end else if (frame_tick) begin
          if (half_q <= 16'd1) begin
            half_d = half_period_of(2'(id_q));
            neg_d  = ~neg_q;
          end else begin
            half_d = half_q - 16'd1;
          end
          if (dur_q <= 16'd1) begin
            dur_d   = 16'd0;
            neg_d   = 1'b0;
            gap_d   = GapLoad;
            state_d = StGap;
          end else begin
            dur_d = dur_q - 16'd1;
          end
        end
      end

      StGap: begin
        if (frame_tick) begin
          if (gap_q <= 16'd1) begin
            gap_d   = 16'd0;
            state_d = StIdle;
`ifdef SOUND_QUEUE_EN
            if (|eligible) begin
              start    = 1'b1;
              start_id = pend_win;
            end
`endif
          end else begin
            gap_d = gap_q - 16'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d         = StPlay;
      id_d            = start_id;
      neg_d           = 1'b0;
      half_d          = half_period_of(2'(start_id));
      dur_d           = duration_of(2'(start_id));
      gap_d           = 16'd0;
      ack_d[start_id] = 1'b1;
    end
  end

`ifdef SOUND_QUEUE_EN
  always_comb begin
    pending_d = pending_q;
    if (state_q != StIdle) pending_d = (pending_q | req) & ~ack_d;
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end
`endif

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      id_q    <= '0;
      neg_q   <= 1'b0;
      half_q  <= 16'd0;
      dur_q   <= 16'd0;
      gap_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      neg_q   <= neg_d;
      half_q  <= half_d;
      dur_q   <= dur_d;
      gap_q   <= gap_d;
    end
  end

  // Samples derive from registered state only, so they hold steady for a whole frame.
  logic [19:0] sample;

  always_comb begin
    sample = 20'h0;
    if (state_q == StPlay) sample = neg_q ? NegAmp : AMP;
  end

  assign ack            = reset ? '0 : ack_d;
  assign busy           = (state_q != StIdle);
  assign active_id      = id_q;
  assign left_out_data  = sample;
  assign right_out_data = sample;

endmodule

// File: tb/tb_sound_scheduler.sv
// Randomized bench for sound_scheduler against a frame-counting reference model.
module tb_sound_scheduler;

  localparam logic [19:0] AMP     = 20'h0_8000;
  localparam logic [19:0] NEG_AMP = 20'hF_8000;
  localparam int          GAP     = 240;

  int hp_tab  [4] = '{10, 16, 24, 40};
  int dur_tab [4] = '{400, 800, 4800, 1600};

  logic        system_clock;
  logic        reset;
  logic        ready;
  logic [3:0]  req;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  active_id;
  logic [19:0] left_out_data;
  logic [19:0] right_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  sound_scheduler dut (
    .system_clock   (system_clock),
    .reset          (reset),
    .ready          (ready),
    .req            (req),
    .ack            (ack),
    .busy           (busy),
    .active_id      (active_id),
    .left_out_data  (left_out_data),
    .right_out_data (right_out_data)
  );

  initial begin
    system_clock = 1'b0;
    forever #5 system_clock = ~system_clock;
  end

  // Frame-ready with jittered levels, never changing on a clock edge.
  initial begin
    ready = 1'b0;
    #3;
    forever begin
      int d;
      d = $urandom_range(34, 12);
      if ((($time + d) % 5) == 0) d++;
      #d ready = ~ready;
    end
  end

  // Reference model: 0 idle, 1 playing, 2 gap; timing in frames since sound start.
  int         m_state = 0;
  int         m_id = 0;
  int         m_elapsed = 0;
  int         m_gap_left = 0;
  int         m_ticks = 0;
  logic [3:0] m_pend = 4'b0;
  logic [3:0] hist = 4'b0;

  function automatic int lowest(logic [3:0] v);
    int r;
    r = -1;
    for (int i = 3; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int eff(int v);
    return (v == 0) ? 1 : v;
  endfunction

  // A codec rising edge becomes a frame two clocks after it is first sampled.
  function automatic logic next_tick();
    return hist[1] & ~hist[2];
  endfunction

  function automatic logic [3:0] exp_ack(logic [3:0] r);
    logic [3:0] a;
    int w;
    a = 4'b0;
    w = lowest(r);
    if (m_state == 0) begin
      if (w >= 0) a[w] = 1'b1;
    end else if (m_state == 1) begin
      if (w >= 0 && w < m_id) a[w] = 1'b1;
    end
`ifdef SOUND_QUEUE_EN
    else if (next_tick() && m_gap_left == 1) begin
      w = lowest(m_pend | r);
      if (w >= 0) a[w] = 1'b1;
    end
`endif
    return a;
  endfunction

  function automatic logic [19:0] exp_sample();
    if (m_state != 1) return 20'h0;
    return (((m_elapsed / eff(hp_tab[m_id])) % 2) == 1) ? NEG_AMP : AMP;
  endfunction

  task automatic summary_and_finish();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at time %0t", name, act, exp, $time);
      if (n_fail >= 50) summary_and_finish();
    end
  endtask

  initial begin
    forever begin
      @(posedge system_clock or posedge reset);
      if (reset) begin
        m_state = 0; m_id = 0; m_elapsed = 0; m_gap_left = 0; m_pend = 4'b0; hist = 4'b0;
      end else begin
        logic       tk;
        logic [3:0] a;
        tk = next_tick();
        a  = exp_ack(req);
        if (tk) m_ticks++;
        if (a != 4'b0) begin
`ifdef SOUND_QUEUE_EN
          if (m_state != 0) m_pend = (m_pend | req) & ~a;
`endif
          m_state   = 1;
          m_id      = lowest(a);
          m_elapsed = 0;
        end else begin
`ifdef SOUND_QUEUE_EN
          if (m_state != 0) m_pend = m_pend | req;
`endif
          if (tk && m_state == 1) begin
            m_elapsed++;
            if (m_elapsed >= eff(dur_tab[m_id])) begin
              m_state    = 2;
              m_gap_left = eff(GAP);
            end
          end else if (tk && m_state == 2) begin
            m_gap_left--;
            if (m_gap_left == 0) m_state = 0;
          end
        end
        hist = {hist[2:0], ready};
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge system_clock);
      if (reset) begin
        check("reset_ack", 20'(ack), 20'h0);
        check("reset_busy", 20'(busy), 20'h0);
        check("reset_active_id", 20'(active_id), 20'h0);
        check("reset_left", left_out_data, 20'h0);
        check("reset_right", right_out_data, 20'h0);
      end else begin
        check("ack", 20'(ack), 20'(exp_ack(req)));
        check("busy", 20'(busy), 20'(m_state != 0));
        check("active_id", 20'(active_id), 20'(m_id));
        check("left", left_out_data, exp_sample());
        check("right", right_out_data, exp_sample());
        check("frame_tick", 20'(dut.frame_tick), 20'(next_tick()));
      end
    end
  end

  task automatic pulse_req(input logic [3:0] v, input logic [3:0] exp_a, input string nm);
    @(posedge system_clock);
    #1 req = v;
    @(negedge system_clock);
    check(nm, 20'(ack), 20'(exp_a));
    @(posedge system_clock);
    #1 req = 4'b0;
  endtask

  task automatic wait_until_tick(input int target);
    int budget;
    budget = (target - m_ticks) * 10 + 20;
    while (m_ticks < target && budget > 0) begin
      @(negedge system_clock);
      budget--;
    end
    check("tick_wait_bound", 20'(m_ticks >= target), 20'h1);
  endtask

  task automatic async_reset_pulse();
    @(negedge system_clock);
    #2 reset = 1'b1;
    #1;
    check("async_reset_busy", 20'(busy), 20'h0);
    check("async_reset_left", left_out_data, 20'h0);
    check("async_reset_right", right_out_data, 20'h0);
    repeat (3) @(negedge system_clock);
    #2 reset = 1'b0;
  endtask

  initial begin
    int t0;
    int budget;
    reset = 1'b1;
    req   = 4'b1111;
    repeat (3) @(negedge system_clock);
    check("rst_ack_masked", 20'(ack), 20'h0);
    check("rst_busy", 20'(busy), 20'h0);
    check("rst_left", left_out_data, 20'h0);
    req = 4'b0;
    #2 reset = 1'b0;
    repeat (10) @(negedge system_clock);

    // Paddle sound: timing of half periods, duration and gap.
    pulse_req(4'b0100, 4'b0100, "idle_ack_id2");
    t0 = m_ticks;
    @(negedge system_clock);
    check("id2_busy", 20'(busy), 20'h1);
    check("id2_active_id", 20'(active_id), 20'h2);
    check("id2_first_left", left_out_data, AMP);
    check("model_id2_first", exp_sample(), AMP);
    wait_until_tick(t0 + 23);
    check("id2_tick23_left", left_out_data, AMP);
    wait_until_tick(t0 + 24);
    check("id2_tick24_left", left_out_data, NEG_AMP);
    check("id2_tick24_right", right_out_data, NEG_AMP);
    check("model_id2_tick24", exp_sample(), NEG_AMP);
    budget = 4800 * 8;
    while (!(busy && left_out_data == 20'h0) && budget > 0) begin
      @(negedge system_clock);
      budget--;
    end
    check("id2_gap_after_4800", 20'(m_ticks - t0), 20'd4800);
    t0 = m_ticks;
    budget = 240 * 8;
    while (busy && budget > 0) begin
      @(negedge system_clock);
      budget--;
    end
    check("id2_idle_after_240", 20'(m_ticks - t0), 20'd240);

    // Preemption by id 0, then a lower-priority request that must be refused.
    pulse_req(4'b0100, 4'b0100, "restart_id2");
    wait_until_tick(m_ticks + 100);
    pulse_req(4'b0001, 4'b0001, "preempt_ack0");
    @(negedge system_clock);
    check("preempt_active_id", 20'(active_id), 20'h0);
    check("preempt_left", left_out_data, AMP);
    pulse_req(4'b1000, 4'b0000, "low_prio_no_ack");
    wait_until_tick(m_ticks + 100);
    check("id2_not_resumed", 20'(active_id), 20'h0);
    async_reset_pulse();
    repeat (20) @(negedge system_clock);
    check("post_reset_idle", 20'(busy), 20'h0);

    // All requesters at once: only index 0 is served.
    pulse_req(4'b1111, 4'b0001, "all_req_ack0");
    t0 = m_ticks;
    @(negedge system_clock);
    check("all_req_left_pos", left_out_data, AMP);
    wait_until_tick(t0 + 10);
    check("all_req_left_neg", left_out_data, NEG_AMP);
    check("model_id0_tick10", exp_sample(), NEG_AMP);
    pulse_req(4'b1000, 4'b0000, "id3_during_id0");
    budget = 800 * 8;
`ifdef SOUND_QUEUE_EN
    while (!(busy && active_id == 2'd3) && budget > 0) begin
      @(negedge system_clock);
      budget--;
    end
    check("queued_id3_started", 20'(active_id), 20'h3);
`else
    while (busy && budget > 0) begin
      @(negedge system_clock);
      budget--;
    end
    check("id3_dropped_idle", 20'(busy), 20'h0);
`endif
    async_reset_pulse();

    // Random request traffic, one mid-run reset.
    for (int c = 0; c < 30000; c++) begin
      @(posedge system_clock);
      #1;
      req = ($urandom_range(99, 0) < 2) ? 4'($urandom_range(15, 1)) : 4'b0;
      if (c == 15000) begin
        req = 4'b0;
        async_reset_pulse();
      end
    end
    req = 4'b0;
    repeat (5) @(negedge system_clock);
    summary_and_finish();
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
    n_fail++;
    summary_and_finish();
  end

endmodule
